// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
// Imported by mem_access_ctrl.
package mem_access_ctrl_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } mem_state_e;

   localparam logic        LwMemSrc     = 1'b1;
   localparam logic        LwAluSrc     = 1'b0;
   localparam logic        RstEnable    = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: drives a req/ack data-memory port, stalls the front end while an access
// is outstanding, aborts hung accesses after TIMEOUT cycles and registers the MEM/WB bundle.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned WADDR_W = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  exe_alu_result,
   input  logic [DATA_W-1:0]  exe_sw_data,
   input  logic [WADDR_W-1:0] exe_write_addr,
   input  logic               exe_reg_write,
   input  logic               exe_lwsrc,
   input  logic               exe_DM_read,
   input  logic               exe_DM_write,
   output logic               mem_stall,
   output logic               dm_req,
   output logic               dm_we,
   output logic [DATA_W-1:0]  dm_addr,
   output logic [DATA_W-1:0]  dm_wdata,
   input  logic               dm_ack,
   input  logic [DATA_W-1:0]  dm_rdata,
   output logic [WADDR_W-1:0] wb_write_addr,
   output logic [DATA_W-1:0]  wb_write_data,
   output logic               wb_reg_write,
   output logic               mem_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

   mem_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dm_req_q, dm_req_d;
   logic               dm_we_q, dm_we_d;
   logic [DATA_W-1:0]  dm_addr_q, dm_addr_d;
   logic [DATA_W-1:0]  dm_wdata_q, dm_wdata_d;
   logic [WADDR_W-1:0] cap_write_addr_q, cap_write_addr_d;
   logic               cap_reg_write_q, cap_reg_write_d;
   logic               cap_lwsrc_q, cap_lwsrc_d;
   logic [WADDR_W-1:0] wb_write_addr_q, wb_write_addr_d;
   logic [DATA_W-1:0]  wb_write_data_q, wb_write_data_d;
   logic               wb_reg_write_q, wb_reg_write_d;
   logic               mem_err_q, mem_err_d;
   logic               access;

   assign access = exe_DM_read | exe_DM_write;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      dm_req_d         = dm_req_q;
      dm_we_d          = dm_we_q;
      dm_addr_d        = dm_addr_q;
      dm_wdata_d       = dm_wdata_q;
      cap_write_addr_d = cap_write_addr_q;
      cap_reg_write_d  = cap_reg_write_q;
      cap_lwsrc_d      = cap_lwsrc_q;
      wb_write_addr_d  = wb_write_addr_q;
      wb_write_data_d  = wb_write_data_q;
      wb_reg_write_d   = wb_reg_write_q;
      mem_err_d        = 1'b0;
      mem_stall        = 1'b0;

      case (state_q)
         StIdle: begin
            if (access) begin
               mem_stall        = 1'b1;
               dm_req_d         = 1'b1;
               dm_we_d          = exe_DM_write;
               dm_addr_d        = exe_alu_result;
               dm_wdata_d       = exe_sw_data;
               cap_write_addr_d = exe_write_addr;
               cap_reg_write_d  = exe_reg_write;
               cap_lwsrc_d      = exe_lwsrc;
               cnt_d            = '0;
               wb_reg_write_d   = WriteDisable;
               state_d          = StWait;
            end else begin
               wb_write_addr_d = exe_write_addr;
               wb_write_data_d = exe_alu_result;
               wb_reg_write_d  = exe_reg_write;
            end
         end
         StWait: begin
            wb_reg_write_d = WriteDisable;
            if (dm_ack) begin
               dm_req_d        = 1'b0;
               state_d         = StIdle;
               wb_write_addr_d = cap_write_addr_q;
               // Stores (including read+write) never write back.
               wb_reg_write_d  = cap_reg_write_q & ~dm_we_q;
               wb_write_data_d = (cap_lwsrc_q == LwMemSrc) ? dm_rdata : dm_addr_q;
            end else if (cnt_q == CntLast) begin
               dm_req_d  = 1'b0;
               mem_err_d = 1'b1;
               state_d   = StIdle;
            end else begin
               mem_stall = 1'b1;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (rst == RstEnable) begin
         mem_stall = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q          <= StIdle;
         cnt_q            <= '0;
         dm_req_q         <= 1'b0;
         dm_we_q          <= WriteDisable;
         dm_addr_q        <= DATA_W'(ZeroWord);
         dm_wdata_q       <= DATA_W'(ZeroWord);
         cap_write_addr_q <= WADDR_W'(ZeroWord);
         cap_reg_write_q  <= WriteDisable;
         cap_lwsrc_q      <= LwAluSrc;
         wb_write_addr_q  <= WADDR_W'(ZeroWord);
         wb_write_data_q  <= DATA_W'(ZeroWord);
         wb_reg_write_q   <= WriteDisable;
         mem_err_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         dm_req_q         <= dm_req_d;
         dm_we_q          <= dm_we_d;
         dm_addr_q        <= dm_addr_d;
         dm_wdata_q       <= dm_wdata_d;
         cap_write_addr_q <= cap_write_addr_d;
         cap_reg_write_q  <= cap_reg_write_d;
         cap_lwsrc_q      <= cap_lwsrc_d;
         wb_write_addr_q  <= wb_write_addr_d;
         wb_write_data_q  <= wb_write_data_d;
         wb_reg_write_q   <= wb_reg_write_d;
         mem_err_q        <= mem_err_d;
      end
   end

   assign dm_req        = dm_req_q;
   assign dm_we         = dm_we_q;
   assign dm_addr       = dm_addr_q;
   assign dm_wdata      = dm_wdata_q;
   assign wb_write_addr = wb_write_addr_q;
   assign wb_write_data = wb_write_data_q;
   assign wb_reg_write  = wb_reg_write_q;
   assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a per-instruction timeline model predicts every output cycle by
// cycle; literal checks pin totals, writeback order and reset behaviour.
module tb_mem_access_ctrl;

   localparam int TMO    = 15;
   localparam int MaxCyc = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] exe_alu_result = '0;
   logic [31:0] exe_sw_data = '0;
   logic [31:0] exe_write_addr = '0;
   logic        exe_reg_write = 1'b0;
   logic        exe_lwsrc = 1'b0;
   logic        exe_DM_read = 1'b0;
   logic        exe_DM_write = 1'b0;
   logic        mem_stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic [31:0] wb_write_addr;
   logic [31:0] wb_write_data;
   logic        wb_reg_write;
   logic        mem_err;

   mem_access_ctrl #(
      .DATA_W  (32),
      .WADDR_W (32),
      .TIMEOUT (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .exe_alu_result (exe_alu_result),
      .exe_sw_data    (exe_sw_data),
      .exe_write_addr (exe_write_addr),
      .exe_reg_write  (exe_reg_write),
      .exe_lwsrc      (exe_lwsrc),
      .exe_DM_read    (exe_DM_read),
      .exe_DM_write   (exe_DM_write),
      .mem_stall      (mem_stall),
      .dm_req         (dm_req),
      .dm_we          (dm_we),
      .dm_addr        (dm_addr),
      .dm_wdata       (dm_wdata),
      .dm_ack         (dm_ack),
      .dm_rdata       (dm_rdata),
      .wb_write_addr  (wb_write_addr),
      .wb_write_data  (wb_write_data),
      .wb_reg_write   (wb_reg_write),
      .mem_err        (mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd, wr, rw, lwsrc, stray;
      logic [31:0] waddr, alu, sw, rdata;
      int          k;   // ack on k-th wait cycle; 0 = never ack
   } instr_t;

   instr_t prog[$];
   instr_t cur;

   int          in_idx[MaxCyc];
   logic        d_ack[MaxCyc];
   logic [31:0] d_rdata[MaxCyc];
   logic        e_stall[MaxCyc], e_req[MaxCyc], e_we[MaxCyc], e_wbrw[MaxCyc], e_err[MaxCyc];
   logic [31:0] e_addr[MaxCyc], e_wdata[MaxCyc], e_wbaddr[MaxCyc], e_wbdata[MaxCyc];
   int          ncyc;

   int          total = 0;
   int          bad = 0;
   int          cur_cyc = 0;
   bit          running = 1'b0;
   int          stall_cnt = 0, req_cnt = 0, err_cnt = 0;
   logic [63:0] wb_q[$];

   task automatic chk(input string nm, input int cyc, input logic [63:0] got,
                      input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
      end
   endtask

   task automatic add(input bit rd, input bit wr, input bit rw, input bit lwsrc,
                      input logic [31:0] waddr, input logic [31:0] alu, input logic [31:0] sw,
                      input int k, input logic [31:0] rdata, input bit stray);
      instr_t t;
      t.rd = rd; t.wr = wr; t.rw = rw; t.lwsrc = lwsrc; t.stray = stray;
      t.waddr = waddr; t.alu = alu; t.sw = sw; t.k = k; t.rdata = rdata;
      prog.push_back(t);
   endtask

   // Timeline: a non-memory op takes one cycle; an access takes a detect cycle plus its wait
   // cycles, stalls on all but the last, and its result (or error) lands one edge later.
   task automatic build_model();
      int cyc;
      int wn;
      instr_t t;
      for (int c = 0; c < MaxCyc; c++) begin
         in_idx[c] = 0; d_ack[c] = 1'b0; d_rdata[c] = 32'hBAD0_0000 + c;
         e_stall[c] = 1'b0; e_req[c] = 1'b0; e_we[c] = 1'b0; e_wbrw[c] = 1'b0;
         e_err[c] = 1'b0; e_addr[c] = '0; e_wdata[c] = '0; e_wbaddr[c] = '0; e_wbdata[c] = '0;
      end
      cyc = 0;
      for (int i = 0; i < prog.size(); i++) begin
         t = prog[i];
         if (!(t.rd || t.wr)) begin
            in_idx[cyc] = i;
            d_ack[cyc] = t.stray;
            e_wbrw[cyc+1] = t.rw; e_wbaddr[cyc+1] = t.waddr; e_wbdata[cyc+1] = t.alu;
            cyc += 1;
         end else begin
            wn = (t.k == 0) ? TMO : t.k;
            for (int j = 0; j <= wn; j++) in_idx[cyc+j] = i;
            for (int j = 0; j < wn; j++) e_stall[cyc+j] = 1'b1;
            for (int j = 1; j <= wn; j++) begin
               e_req[cyc+j] = 1'b1; e_we[cyc+j] = t.wr;
               e_addr[cyc+j] = t.alu; e_wdata[cyc+j] = t.sw; e_wbrw[cyc+j] = 1'b0;
            end
            if (t.k != 0) begin
               d_ack[cyc+t.k] = 1'b1; d_rdata[cyc+t.k] = t.rdata;
               e_wbrw[cyc+t.k+1] = t.rw && !t.wr;
               e_wbaddr[cyc+t.k+1] = t.waddr;
               e_wbdata[cyc+t.k+1] = t.lwsrc ? t.rdata : t.alu;
            end else begin
               e_err[cyc+wn+1] = 1'b1;
               e_wbrw[cyc+wn+1] = 1'b0;
            end
            cyc += wn + 1;
         end
      end
      ncyc = cyc;
   endtask

   always @(negedge clk) begin
      if (running) begin
         chk("mem_stall", cur_cyc, mem_stall, e_stall[cur_cyc]);
         chk("dm_req", cur_cyc, dm_req, e_req[cur_cyc]);
         if (e_req[cur_cyc]) begin
            chk("dm_we", cur_cyc, dm_we, e_we[cur_cyc]);
            chk("dm_addr", cur_cyc, dm_addr, e_addr[cur_cyc]);
            chk("dm_wdata", cur_cyc, dm_wdata, e_wdata[cur_cyc]);
         end
         chk("wb_reg_write", cur_cyc, wb_reg_write, e_wbrw[cur_cyc]);
         if (e_wbrw[cur_cyc]) begin
            chk("wb_write_addr", cur_cyc, wb_write_addr, e_wbaddr[cur_cyc]);
            chk("wb_write_data", cur_cyc, wb_write_data, e_wbdata[cur_cyc]);
         end
         chk("mem_err", cur_cyc, mem_err, e_err[cur_cyc]);
         if (mem_stall) stall_cnt++;
         if (dm_req) req_cnt++;
         if (mem_err) err_cnt++;
         if (wb_reg_write) wb_q.push_back({wb_write_addr, wb_write_data});
      end
   end

   initial begin
      //    rd wr rw ls waddr  alu           sw          k  rdata         stray
      add(0, 0, 1, 0, 5,  32'h1234, 0,          0, 0,            0);
      add(1, 0, 1, 1, 7,  32'h100,  0,          3, 32'hDEADBEEF, 0);
      add(0, 1, 1, 0, 8,  32'h40,   32'hA5A5,   1, 0,            0);
      add(0, 0, 1, 0, 9,  32'h55,   0,          0, 0,            1);
      add(1, 0, 1, 1, 3,  32'h200,  0,          0, 0,            0);
      add(0, 0, 1, 0, 10, 32'h77,   0,          0, 0,            0);
      add(1, 0, 1, 1, 11, 32'h300,  0,          1, 32'h11112222, 0);
      add(1, 0, 1, 1, 12, 32'h304,  0,          2, 32'h33334444, 0);
      add(1, 0, 1, 0, 13, 32'h400,  0,          1, 32'h99,       0);
      add(1, 1, 1, 1, 14, 32'h500,  32'hBEEF,   2, 32'h5555,     0);
      add(0, 0, 0, 0, 15, 32'h66,   0,          0, 0,            0);
      add(0, 0, 1, 0, 1,  32'hCAFE, 0,          0, 0,            0);
      add(0, 0, 0, 0, 0,  0,        0,          0, 0,            0);
      build_model();

      // Reset: access requested but stall must stay low.
      exe_DM_read = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", -1, mem_stall, 1'b0);
      chk("rst_req", -1, dm_req, 1'b0);
      chk("rst_wbrw", -1, wb_reg_write, 1'b0);
      chk("rst_err", -1, mem_err, 1'b0);
      rst = 1'b0;

      for (int c = 0; c < ncyc; c++) begin
         cur_cyc = c;
         cur = prog[in_idx[c]];
         exe_DM_read = cur.rd; exe_DM_write = cur.wr; exe_reg_write = cur.rw;
         exe_lwsrc = cur.lwsrc; exe_write_addr = cur.waddr; exe_alu_result = cur.alu;
         exe_sw_data = cur.sw;
         dm_ack = d_ack[c]; dm_rdata = d_rdata[c];
         running = 1'b1;
         @(posedge clk);
         #1;
      end
      running = 1'b0;

      chk("pin_cycles", -1, ncyc, 38);
      chk("pin_stall_total", -1, stall_cnt, 25);
      chk("pin_req_total", -1, req_cnt, 25);
      chk("pin_err_pulses", -1, err_cnt, 1);
      chk("pin_wb_count", -1, wb_q.size(), 8);
      chk("pin_wb0", -1, wb_q[0], {32'd5, 32'h1234});
      chk("pin_wb1", -1, wb_q[1], {32'd7, 32'hDEADBEEF});
      chk("pin_wb5", -1, wb_q[5], {32'd12, 32'h33334444});
      chk("pin_wb6", -1, wb_q[6], {32'd13, 32'h400});
      chk("pin_wb7", -1, wb_q[7], {32'd1, 32'hCAFE});

      // Reset while waiting on an access that never acks.
      exe_DM_read = 1'b1; exe_DM_write = 1'b0; exe_reg_write = 1'b1; exe_lwsrc = 1'b1;
      exe_write_addr = 32'd20; exe_alu_result = 32'h600; dm_ack = 1'b0;
      #1;
      chk("p2_detect_stall", -1, mem_stall, 1'b1);
      @(posedge clk);
      #1;
      chk("p2_wait_req", -1, dm_req, 1'b1);
      chk("p2_wait_addr", -1, dm_addr, 32'h600);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("p2_rst_req", -1, dm_req, 1'b0);
      chk("p2_rst_stall", -1, mem_stall, 1'b0);
      chk("p2_rst_wbrw", -1, wb_reg_write, 1'b0);
      chk("p2_rst_wbaddr", -1, wb_write_addr, 32'd0);
      chk("p2_rst_wbdata", -1, wb_write_data, 32'd0);
      chk("p2_rst_err", -1, mem_err, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // ALU op with a stray ack: IDLE must treat it as a plain writeback.
      exe_DM_read = 1'b0; exe_reg_write = 1'b1; exe_write_addr = 32'd2;
      exe_alu_result = 32'h42; dm_ack = 1'b1; dm_rdata = 32'h7777_7777;
      #1;
      chk("p2_idle_stall", -1, mem_stall, 1'b0);
      @(posedge clk);
      #1;
      dm_ack = 1'b0; exe_reg_write = 1'b0;
      chk("p2_stray_req", -1, dm_req, 1'b0);
      chk("p2_stray_err", -1, mem_err, 1'b0);
      chk("p2_alu_wbrw", -1, wb_reg_write, 1'b1);
      chk("p2_alu_wbaddr", -1, wb_write_addr, 32'd2);
      chk("p2_alu_wbdata", -1, wb_write_data, 32'h42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
